pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Parametrised multi-channel PWM generator and successor to the fixed 8-bit single-duty PWM block. It drives up to `CHANNELS` independent PWM outputs from one shared time base, and that time base has a programmable prescaler, a programmable period and an edge-aligned or centre-aligned counting mode. Duty values go into per-channel shadow registers through a simple write port. Shadow values, period and prescale are applied glitch-free only at a period boundary. The block sits between the `ui_in` configuration decode and the `uo_out` pad drivers.

## Interface
- `CHANNELS`, 4: number of PWM outputs (1..8).
- `WIDTH`, 8: width of the counter, period and duty.
- `PRESC_W`, 8: width of the prescaler.
- `AW`, `$clog2(CHANNELS)` (min 1): width of the write address.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: block enable.
- `wr_en` in 1: one-cycle duty write strobe.
- `wr_addr` in AW: channel index for `wr_data`.
- `wr_data` in WIDTH: duty value to write into the shadow register.
- `period` in WIDTH: counter top value P; sampled at the boundary.
- `prescale` in PRESC_W: tick every `prescale+1` clocks; sampled at the boundary.
- `center_mode` in 1: 0 selects edge-aligned, 1 selects centre-aligned; sampled at the boundary.
- `invert` in CHANNELS: per-channel output polarity; applied live.
- `pwm_out` out CHANNELS: registered PWM outputs.
- `period_tick` out 1: one-clock pulse at each period boundary.

## Operation

Prescaler
- `pcnt` counts 0..`prescale_a`.
- `tick`=1 when `pcnt`==`prescale_a`; at that point `pcnt` returns to 0.

Main counter, advances only on `tick`
- Edge mode: `cnt` runs 0,1..P_a, then back to 0.
- Centre mode: `cnt` runs 0,1..P_a, then counts down P_a-1..1 to 0, then counts up again.
  - Direction flag `dir`: up=0, down=1. It flips to down when `cnt`==P_a and to up when `cnt`==1 while down.
- P_a=0 in either mode: `cnt` stays at 0 and every tick is a boundary.

Boundary
- Edge mode: a tick with `cnt`==P_a.
- Centre mode: a tick with `cnt`==1 while `dir`=down.
- P_a=0: every tick.
- At the boundary, all `duty_a[i]`, P_a, `prescale_a` and the mode are loaded from the shadow registers and inputs.
- The first boundary after reset is forced on the first tick, which loads the configuration.

Shadow writes
- `wr_en` with `wr_addr`<CHANNELS writes `duty_s[wr_addr]`.
- Out-of-range addresses are ignored.
- A write in the same cycle as a boundary is write-through: the new value goes into `duty_a`.

Compare
- Raw output: `raw[i]` = (`cnt` < `duty_a[i]`).
- Pins: `pwm_out[i]` is registered and equals `raw[i]` XOR `invert[i]`.
- `duty_a`=0 gives constant low.
- `duty_a` > P_a gives constant high (100%).
- Edge mode: high time is `duty_a` ticks per P_a+1 ticks.
- Centre mode: high time is 2·`duty_a` − 1 ticks per 2·P_a ticks, symmetric about `cnt`=0.

Enable
- `ena`=0 clears `pcnt`, `cnt` and `dir`, and forces `pwm_out`=0 and `period_tick`=0.
- Shadow writes are still accepted while `ena`=0.
- On `ena` rising, the first tick is treated as a forced boundary.

Arithmetic
- All compares are unsigned at WIDTH bits.
- No counter ever exceeds its active limit, so no overflow path exists.

## Timing
Reset (async, `rst_n`=0) clears the following:
- `pwm_out`=0 and `period_tick`=0.
- `pcnt`=0, `cnt`=0, `dir`=up.
- All `duty_s`/`duty_a`=0, P_a=0, `prescale_a`=0, mode=edge.
- A `rst_n` assert mid-period aborts the period immediately; no partial pulse is produced.

Latency
- `pwm_out` is one clock after the `cnt` value it reflects.
- `period_tick` is registered and pulses in the clock after the boundary tick.
- A write lands in `duty_s` at the next edge and reaches the output at the next boundary plus one clock.
- `invert` reaches `pwm_out` in one clock, independent of the boundary.

Period length
- Edge mode: (P+1)·(prescale+1) clocks.
- Centre mode: 2P·(prescale+1) clocks.

## Test plan
1. Edge, P=9, prescale=0, duty0=3 written once, then one boundary.
   - Requires: `pwm_out[0]` high 3 clocks and low 7 clocks, repeating; `period_tick` every 10 clocks.
2. Centre, P=4, prescale=1, duty1=2.
   - Requires: period 16 clocks; `pwm_out[1]` high 6 consecutive clocks (`cnt`∈{1,0,1} spans 3 ticks) per period, centred.
3. Duty 0 and duty 12 with P=10.
   - Requires: the duty-0 channel is constant 0 and the duty-12 channel is constant 1; `invert`=1 flips both within one clock.
4. Shadow update mid-period: write duty0=8 while `cnt`=2 (active 3).
   - Requires: the current period still shows 3 high ticks; the next period shows 8.
   - A write coincident with the boundary tick is applied to the immediately following period.
5. `ena` dropped mid-period, then raised.
   - Requires: outputs go 0 within one clock and `cnt`=0; after re-enable, output resumes from `cnt`=0 with the new configuration.
   - A `wr_addr`=CHANNELS write leaves all duties unchanged.
6. `rst_n` pulsed low asynchronously between clock edges during a high phase.
   - Requires: `pwm_out` and `period_tick` are 0 immediately.
   - Requires: after release, all channels stay low until duties are written and a boundary has passed.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared prescaled time base (edge- or centre-aligned)
// feeding per-channel compare lanes with shadow/active duty registers.

module pwm_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] cnt,
  input  logic             invert,
  output logic             pwm_out
);
  logic [WIDTH-1:0] duty_s, duty_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_s  <= '0;
      duty_a  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr_hit) duty_s <= wr_data;
      // a write landing on the boundary goes straight into the active register
      if (load) duty_a <= wr_hit ? wr_data : duty_s;
      pwm_out <= ena & ((cnt < duty_a) ^ invert);
    end
  end
endmodule

module pwm_multi_ch #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 8,
  parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [WIDTH-1:0]    period,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic                center_mode,
  input  logic [CHANNELS-1:0] invert,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);
  typedef struct packed {
    logic [WIDTH-1:0]   per;
    logic [PRESC_W-1:0] pre;
    logic               center;
  } cfg_t;

  cfg_t               cfg_a;
  logic [PRESC_W-1:0] pcnt;
  logic [WIDTH-1:0]   cnt;
  logic               dir;
  logic               force_bnd;
  logic               tick;
  logic               boundary;

  assign tick = ena && (pcnt == cfg_a.pre);

  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (force_bnd || cfg_a.per == '0)
        boundary = 1'b1;
      else if (!cfg_a.center)
        boundary = (cnt == cfg_a.per);
      else
        // P=1 centre never reaches cnt==1 while down, so its turn-around is the boundary
        boundary = dir ? (cnt == WIDTH'(1))
                       : (cnt == WIDTH'(1) && cfg_a.per == WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_a       <= '0;
      pcnt        <= '0;
      cnt         <= '0;
      dir         <= 1'b0;
      force_bnd   <= 1'b1;
      period_tick <= 1'b0;
    end else if (!ena) begin
      pcnt        <= '0;
      cnt         <= '0;
      dir         <= 1'b0;
      force_bnd   <= 1'b1;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      pcnt        <= tick ? '0 : pcnt + 1'b1;
      if (boundary) begin
        cnt       <= '0;
        dir       <= 1'b0;
        force_bnd <= 1'b0;
        cfg_a     <= '{per: period, pre: prescale, center: center_mode};
      end else if (tick) begin
        if (!cfg_a.center)         cnt <= cnt + 1'b1;
        else if (dir)              cnt <= cnt - 1'b1;
        else if (cnt == cfg_a.per) begin
          dir <= 1'b1;
          cnt <= cnt - 1'b1;
        end else                   cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .load    (boundary),
      .wr_hit  (wr_en && (wr_addr == AW'(i))),
      .wr_data (wr_data),
      .cnt     (cnt),
      .invert  (invert[i]),
      .pwm_out (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: phase-based reference model feeding a per-clock scoreboard,
// plus directed duty/period measurements over fixed windows.

module tb_pwm_multi_ch;
  localparam int CH = 3;

  logic          clk = 1'b0;
  logic          rst_n, ena, wr_en, center_mode, period_tick;
  logic [1:0]    wr_addr;
  logic [7:0]    wr_data, period, prescale;
  logic [CH-1:0] invert, pwm_out;

  pwm_multi_ch #(.CHANNELS(CH), .WIDTH(8), .PRESC_W(8), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .period(period), .prescale(prescale),
    .center_mode(center_mode), .invert(invert), .pwm_out(pwm_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { logic [CH-1:0] pwm; logic tick; } exp_t;
  exp_t sbq[$];

  // Model state: m_k is the clock phase within the current period (or within the
  // forced-boundary wait when m_first is set).
  int m_k = 0, m_P = 0, m_pre = 0;
  bit m_mode = 0, m_first = 1;
  int m_da[CH], m_ds[CH];

  initial forever begin
    exp_t e;
    int   t, c, len;
    bit   bnd;
    @(posedge clk);
    e.pwm = '0;
    e.tick = 1'b0;
    if (!rst_n) begin
      m_k = 0; m_first = 1; m_P = 0; m_pre = 0; m_mode = 0;
      for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
    end else if (!ena) begin
      m_k = 0; m_first = 1;
    end else begin
      t = m_k / (m_pre + 1);
      if (m_first || !m_mode) c = m_first ? 0 : t;
      else                    c = (t <= m_P) ? t : 2 * m_P - t;
      for (int i = 0; i < CH; i++) e.pwm[i] = (c < m_da[i]) ^ invert[i];
      if (m_P == 0)    len = m_pre + 1;
      else if (m_mode) len = 2 * m_P * (m_pre + 1);
      else             len = (m_P + 1) * (m_pre + 1);
      bnd = m_first ? (m_k == m_pre) : (m_k == len - 1);
      e.tick = bnd;
      if (bnd) begin
        for (int i = 0; i < CH; i++)
          m_da[i] = (wr_en && int'(wr_addr) == i) ? int'(wr_data) : m_ds[i];
        m_P = int'(period); m_pre = int'(prescale); m_mode = center_mode;
        m_k = 0; m_first = 0;
      end else m_k++;
    end
    if (rst_n && wr_en && int'(wr_addr) < CH) m_ds[wr_addr] = int'(wr_data);
    sbq.push_back(e);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_pwm", 32'(pwm_out), 32'(e.pwm));
      chk("sb_tick", 32'(period_tick), 32'(e.tick));
    end
  end

  int hi[CH], tk, run;

  task automatic sample(input int ch, input int n);
    int cur = 0;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    tk = 0; run = 0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) if (pwm_out[i]) hi[i]++;
      if (pwm_out[ch]) begin cur++; if (cur > run) run = cur; end else cur = 0;
      if (period_tick) tk++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_k(input int k);
    int n = 0;
    @(negedge clk);
    while (!(m_k == k && !m_first) && n < 200) begin @(negedge clk); n++; end
    chk("wait_phase", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!period_tick && n < 200) begin @(negedge clk); n++; end
    chk("wait_tick", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    period = 8'd9; prescale = 8'd0; center_mode = 1'b0; invert = '0;
    @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;

    // edge, P=9, duty0=3
    wr(0, 3);
    ena = 1'b1;
    cyc(2);
    sample(0, 20);
    chk("t1_hi0", hi[0], 6);
    chk("t1_ticks", tk, 2);
    chk("t1_run", run, 3);

    // shadow write mid-period, then a write coincident with the boundary
    wait_k(2);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd8;
    @(negedge clk); wr_en = 1'b0;
    wait_tick();
    sample(0, 10);
    chk("t4_hi_next", hi[0], 8);
    wait_k(9);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd5;
    @(negedge clk); wr_en = 1'b0;
    chk("t4_bnd_tick", 32'(period_tick), 32'd1);
    sample(0, 10);
    chk("t4_hi_wt", hi[0], 5);

    // centre, P=4, prescale=1, duty1=2
    center_mode = 1'b1; period = 8'd4; prescale = 8'd1;
    wr(1, 2);
    cyc(30);
    sample(1, 48);
    chk("t2_hi1", hi[1], 18);
    chk("t2_ticks", tk, 3);
    chk("t2_run", run, 6);

    // duty 0 and duty > P, plus live invert
    center_mode = 1'b0; period = 8'd10; prescale = 8'd0;
    wr(0, 0);
    wr(2, 12);
    cyc(40);
    sample(0, 22);
    chk("t3_hi0", hi[0], 0);
    chk("t3_hi2", hi[2], 22);
    chk("t3_ticks", tk, 2);
    invert = 3'b101;
    @(negedge clk);
    chk("t3_inv0", 32'(pwm_out[0]), 32'd1);
    chk("t3_inv2", 32'(pwm_out[2]), 32'd0);
    invert = '0;

    // enable dropped mid-period, out-of-range write, re-enable with new config
    wait_k(4);
    ena = 1'b0;
    @(negedge clk);
    chk("t5_off_pwm", 32'(pwm_out), 32'd0);
    chk("t5_off_tick", 32'(period_tick), 32'd0);
    wr(3, 7);
    wr(0, 4);
    period = 8'd5;
    cyc(3);
    chk("t5_off_hold", 32'(pwm_out), 32'd0);
    ena = 1'b1;
    cyc(10);
    sample(0, 12);
    chk("t5_hi0", hi[0], 8);
    chk("t5_hi1", hi[1], 4);
    chk("t5_hi2", hi[2], 12);
    chk("t5_ticks", tk, 2);

    // async reset during a high phase
    n = 0;
    @(negedge clk);
    while (!pwm_out[0] && n < 50) begin @(negedge clk); n++; end
    chk("t6_wait_high", 32'(n < 50), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_tick", 32'(period_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sample(0, 20);
    chk("t6_lo0", hi[0], 0);
    chk("t6_lo1", hi[1], 0);
    chk("t6_lo2", hi[2], 0);
    wr(0, 3);
    wr(1, 6);
    cyc(15);
    sample(0, 12);
    chk("t6_hi0", hi[0], 6);
    chk("t6_hi1", hi[1], 12);
    chk("t6_hi2", hi[2], 0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
